// File: rtl/y86_pkg.sv
// Shared definitions for the sequential Y86-64 core controller.
// Provides icode constants, Y86 status codes, stage indices, the sequencer
// state encoding, and helpers mapping a state to its stage start/done bit.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_OPQ  = 4'h6;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [2:0] STAT_TMO = 3'd5;

    localparam int unsigned STAGE_FETCH  = 0;
    localparam int unsigned STAGE_DECODE = 1;
    localparam int unsigned STAGE_EXEC   = 2;
    localparam int unsigned STAGE_MEM    = 3;
    localparam int unsigned STAGE_WB     = 4;
    localparam int unsigned STAGE_PCUP   = 5;
    localparam int unsigned NUM_STAGES   = 6;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_MEM    = 3'd4;
    localparam state_t ST_WB     = 3'd5;
    localparam state_t ST_PCUP   = 3'd6;
    localparam state_t ST_HALTED = 3'd7;

    function automatic logic is_stage_state(input state_t s);
        return (s != ST_IDLE) && (s != ST_HALTED);
    endfunction

    // One-hot start/done bit belonging to a stage state; zero otherwise.
    function automatic logic [NUM_STAGES-1:0] stage_onehot(input state_t s);
        logic [NUM_STAGES-1:0] oh;
        oh = '0;
        case (s)
            ST_FETCH:  oh[STAGE_FETCH]  = 1'b1;
            ST_DECODE: oh[STAGE_DECODE] = 1'b1;
            ST_EXEC:   oh[STAGE_EXEC]   = 1'b1;
            ST_MEM:    oh[STAGE_MEM]    = 1'b1;
            ST_WB:     oh[STAGE_WB]     = 1'b1;
            ST_PCUP:   oh[STAGE_PCUP]   = 1'b1;
            default:   oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage wait counter with timeout flag.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clear       - zero the counter (stage entry)
//   enable      - count this cycle (stage active, no done)
//   timeout     - counter has reached TIMEOUT_CYCLES
// The counter value equals the number of cycles since the start cycle.
module stage_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !timeout) begin
            // Saturates at the limit; the sequencer leaves the stage anyway.
            count_q <= count_q + CW'(1);
        end
    end

    assign timeout = (count_q == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/seq_stage_sequencer.sv
// Central controller for the sequential Y86-64 core.
// Walks each instruction through fetch, decode, execute, memory, writeback and
// pc-update with a one-cycle start pulse per stage, waiting for that stage's
// done pulse. Faults (halt, bad instruction, address error, stage timeout)
// freeze the core in HALTED with a Y86 status code until reset.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   run              - permits starting new instructions
//   stage_done[5:0]  - per-stage done pulses (fetch..pc-update)
//   f_icode, f_instr_valid, f_imem_error - fetch results, valid with fetch done
//   m_dmem_error     - data memory error, valid with memory done
//   stage_start[5:0] - one-cycle start pulse per stage
//   cc_we            - condition-code write strobe after an OPq execute
//   busy, halted     - in a stage state / in HALTED
//   stat             - Y86 status code
//   instr_count      - retired instruction count
module seq_stage_sequencer
    import y86_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned COUNT_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic [5:0]             stage_done,
    input  logic [3:0]             f_icode,
    input  logic                   f_instr_valid,
    input  logic                   f_imem_error,
    input  logic                   m_dmem_error,
    output logic [5:0]             stage_start,
    output logic                   cc_we,
    output logic                   busy,
    output logic                   halted,
    output logic [2:0]             stat,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    state_t                 state_q, state_d;
    logic [5:0]             start_q, start_d;
    logic                   cc_we_q, cc_we_d;
    logic [2:0]             stat_q, stat_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [3:0]             icode_q, icode_d;
    logic                   done_hit, timeout;

    // start_q is non-zero only in a stage's first cycle, so it masks done there.
    assign done_hit = is_stage_state(state_q) && (start_q == '0) &&
                      ((stage_done & stage_onehot(state_q)) != '0);

    stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_d != '0),
        .enable (is_stage_state(state_q) && !done_hit),
        .timeout(timeout)
    );

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        count_d = count_q;
        icode_d = icode_q;
        cc_we_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                if (done_hit) begin
                    case (state_q)
                        ST_FETCH: begin
                            icode_d = f_icode;
                            if (f_imem_error) begin
                                stat_d  = STAT_ADR;
                                state_d = ST_HALTED;
                            end else if (!f_instr_valid) begin
                                stat_d  = STAT_INS;
                                state_d = ST_HALTED;
                            end else if (f_icode == ICODE_HALT) begin
                                stat_d  = STAT_HLT;
                                state_d = ST_HALTED;
                            end else begin
                                state_d = ST_DECODE;
                            end
                        end
                        ST_DECODE: state_d = ST_EXEC;
                        ST_EXEC: begin
                            cc_we_d = (icode_q == ICODE_OPQ);
                            state_d = ST_MEM;
                        end
                        ST_MEM: begin
                            if (m_dmem_error) begin
                                stat_d  = STAT_ADR;
                                state_d = ST_HALTED;
                            end else begin
                                state_d = ST_WB;
                            end
                        end
                        ST_WB: state_d = ST_PCUP;
                        ST_PCUP: begin
                            count_d = count_q + COUNT_WIDTH'(1);
                            state_d = run ? ST_FETCH : ST_IDLE;
                        end
                        default: state_d = state_q;
                    endcase
                end else if (timeout) begin
                    // A done in the timeout cycle took the branch above instead.
                    stat_d  = STAT_TMO;
                    state_d = ST_HALTED;
                end
            end
        endcase
        // Every entry into a stage state is a change of state, never a self-loop.
        start_d = (state_d != state_q) ? stage_onehot(state_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            start_q <= '0;
            cc_we_q <= 1'b0;
            stat_q  <= STAT_AOK;
            count_q <= '0;
            icode_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            cc_we_q <= cc_we_d;
            stat_q  <= stat_d;
            count_q <= count_d;
            icode_q <= icode_d;
        end
    end

    assign stage_start = start_q;
    assign cc_we       = cc_we_q;
    assign busy        = is_stage_state(state_q);
    assign halted      = (state_q == ST_HALTED);
    assign stat        = stat_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_seq_stage_sequencer.sv
// Directed bench for seq_stage_sequencer. Inputs change and outputs are
// sampled on the falling edge; each step() advances one clock cycle.
module tb_seq_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [5:0]  stage_done = '0;
    logic [3:0]  f_icode = '0;
    logic        f_instr_valid = 1'b0;
    logic        f_imem_error = 1'b0;
    logic        m_dmem_error = 1'b0;
    logic [5:0]  stage_start;
    logic        cc_we;
    logic        busy;
    logic        halted;
    logic [2:0]  stat;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_stage_sequencer #(
        .TIMEOUT_CYCLES(64),
        .COUNT_WIDTH   (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .stage_done   (stage_done),
        .f_icode      (f_icode),
        .f_instr_valid(f_instr_valid),
        .f_imem_error (f_imem_error),
        .m_dmem_error (m_dmem_error),
        .stage_start  (stage_start),
        .cc_we        (cc_we),
        .busy         (busy),
        .halted       (halted),
        .stat         (stat),
        .instr_count  (instr_count)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " start"}, stage_start, 0);
        chk({tag, " cc_we"}, cc_we, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " halted"}, halted, 0);
        chk({tag, " stat"}, stat, 1);
        chk({tag, " count"}, instr_count, 0);
    endtask

    // One-cycle reset with run high: the next step lands on the fetch start cycle.
    task automatic reset_and_go();
        stage_done = '0;
        rst_n = 1'b0;
        run = 1'b1;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Called in a stage's start cycle; answers done one cycle later.
    task automatic single_stage(input int idx, input logic exp_cc, input string tag);
        logic [5:0] oh;
        oh = 6'b000001 << idx;
        chk({tag, " start"}, stage_start, oh);
        chk({tag, " cc_we"}, cc_we, exp_cc);
        step();
        chk({tag, " pulse"}, stage_start, 0);
        stage_done = oh;
        step();
        stage_done = '0;
    endtask

    task automatic instr(input logic [3:0] icode, input string tag);
        f_icode = icode;
        f_instr_valid = 1'b1;
        f_imem_error = 1'b0;
        single_stage(0, 1'b0, {tag, " fetch"});
        single_stage(1, 1'b0, {tag, " decode"});
        single_stage(2, 1'b0, {tag, " exec"});
        single_stage(3, icode == 4'h6, {tag, " mem"});
        single_stage(4, 1'b0, {tag, " wb"});
        single_stage(5, 1'b0, {tag, " pcup"});
    endtask

    // Called in the fetch start cycle; fetch done carries a fault.
    task automatic fault_fetch(input logic [3:0] icode, input logic valid, input logic err,
                               input logic [2:0] exp_stat, input int exp_count,
                               input string tag);
        logic [5:0] acc;
        chk({tag, " fetch start"}, stage_start, 1);
        f_icode = icode;
        f_instr_valid = valid;
        f_imem_error = err;
        step();
        stage_done = 6'b000001;
        step();
        stage_done = '0;
        chk({tag, " halted"}, halted, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " stat"}, stat, exp_stat);
        acc = '0;
        repeat (100) begin
            step();
            acc = acc | stage_start;
        end
        chk({tag, " no starts"}, acc, 0);
        chk({tag, " stat hold"}, stat, exp_stat);
        chk({tag, " count hold"}, instr_count, exp_count);
        chk({tag, " still halted"}, halted, 1);
    endtask

    initial begin
        // Reset with run low: reset values, then stays idle.
        step();
        step();
        rst_n = 1'b1;
        chk_reset_vals("reset");
        step();
        chk("idle no start", stage_start, 0);

        // OPq with single-cycle stages; next fetch at cycle 12.
        run = 1'b1;
        step();
        instr(4'h6, "opq");
        chk("opq next fetch", stage_start, 1);
        chk("opq count", instr_count, 1);

        // Halt after one retired instruction; run remains high and is ignored.
        fault_fetch(4'h0, 1'b1, 1'b0, 3'd2, 1, "hlt");

        reset_and_go();
        fault_fetch(4'h6, 1'b0, 1'b0, 3'd4, 0, "ins");

        // Address error outranks invalid instruction and halt icode.
        reset_and_go();
        fault_fetch(4'h0, 1'b0, 1'b1, 3'd3, 0, "adr");

        // Memory never completes: timeout.
        reset_and_go();
        f_icode = 4'h3;
        f_instr_valid = 1'b1;
        f_imem_error = 1'b0;
        single_stage(0, 1'b0, "to fetch");
        single_stage(1, 1'b0, "to decode");
        single_stage(2, 1'b0, "to exec");
        chk("to mem start", stage_start, 6'b001000);
        chk("to no cc_we", cc_we, 0);
        repeat (64) step();
        chk("to cyc64 halted", halted, 0);
        chk("to cyc64 busy", busy, 1);
        step();
        chk("to halted", halted, 1);
        chk("to stat", stat, 5);
        chk("to busy", busy, 0);

        // Done exactly at the timeout cycle wins.
        reset_and_go();
        single_stage(0, 1'b0, "late fetch");
        single_stage(1, 1'b0, "late decode");
        single_stage(2, 1'b0, "late exec");
        chk("late mem start", stage_start, 6'b001000);
        repeat (64) step();
        stage_done = 6'b001000;
        step();
        stage_done = '0;
        chk("late wb start", stage_start, 6'b010000);
        chk("late stat", stat, 1);
        chk("late halted", halted, 0);

        // run dropped during execute: instruction completes, then park in idle.
        reset_and_go();
        f_icode = 4'h3;
        single_stage(0, 1'b0, "rd fetch");
        single_stage(1, 1'b0, "rd decode");
        run = 1'b0;
        single_stage(2, 1'b0, "rd exec");
        single_stage(3, 1'b0, "rd mem");
        single_stage(4, 1'b0, "rd wb");
        single_stage(5, 1'b0, "rd pcup");
        chk("rd no fetch", stage_start, 0);
        chk("rd idle busy", busy, 0);
        chk("rd count", instr_count, 1);
        step();
        step();
        chk("rd still idle", stage_start, 0);
        run = 1'b1;
        step();
        chk("rd restart", stage_start, 1);

        // Done in the start cycle and on foreign bits are ignored.
        reset_and_go();
        chk("sp fetch start", stage_start, 1);
        f_icode = 4'h0;
        f_instr_valid = 1'b1;
        stage_done = 6'b111111;
        step();
        stage_done = 6'b111110;
        chk("sp cyc1 halted", halted, 0);
        chk("sp cyc1 start", stage_start, 0);
        step();
        chk("sp cyc2 start", stage_start, 0);
        chk("sp cyc2 busy", busy, 1);
        chk("sp cyc2 halted", halted, 0);
        f_icode = 4'h6;
        stage_done = 6'b000001;
        step();
        stage_done = '0;
        single_stage(1, 1'b0, "sp decode");
        single_stage(2, 1'b0, "sp exec");
        single_stage(3, 1'b1, "sp mem");
        single_stage(4, 1'b0, "sp wb");
        single_stage(5, 1'b0, "sp pcup");
        chk("sp count", instr_count, 1);

        // Two more instructions, then reset in the middle of writeback.
        instr(4'h3, "i2");
        instr(4'h6, "i3");
        chk("i3 count", instr_count, 3);
        single_stage(0, 1'b0, "i4 fetch");
        single_stage(1, 1'b0, "i4 decode");
        single_stage(2, 1'b0, "i4 exec");
        single_stage(3, 1'b1, "i4 mem");
        chk("i4 wb start", stage_start, 6'b010000);
        step();
        rst_n = 1'b0;
        stage_done = 6'b010000;
        step();
        rst_n = 1'b1;
        stage_done = '0;
        run = 1'b0;
        chk_reset_vals("wb reset");
        step();
        chk("wb reset no pcup", stage_start, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
